// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM states, word geometry
// and the end-of-word test used by the shifter.
package spi_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BITS  = WORD_BYTES * BYTE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True on the last bit of a word: byte 3 bit 7 when framed, byte 0 bit 7 in OOB.
  function automatic logic is_last_bit(input logic       framed,
                                       input logic [1:0] byte_cnt,
                                       input logic [2:0] bit_cnt);
    logic [1:0] last_byte;
    last_byte = framed ? 2'(WORD_BYTES - 1) : 2'd0;
    return (bit_cnt == 3'(BYTE_BITS - 1)) && (byte_cnt == last_byte);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-flop synchroniser for one asynchronous input; reset loads rst_val into
// every stage so the synchronised output starts from a known idle level.
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift chain: ff[0] captures the raw input, ff[N-1] is the safe output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {N{rst_val}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < N; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave (mode 0, LSB first) that turns bus traffic into a received-word
// stream and feeds a transmit-word stream back onto spi_miso.
//
// Handshakes: both streams use valid/ready. A word moves on a rising clk edge
// where valid and ready are both 1. The producer holds valid and data stable
// until that edge; ready may be high with valid low, which moves nothing.
// On rx the slave is the producer; on tx the slave raises tx_ready only for
// the single LOAD cycle, so tx_data is taken exactly then or not at all.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic        spi_miso,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] rx_data,
  output logic        rx_oob,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        err_overflow,
  output logic        err_underrun,
  output logic        err_frame,
  input  logic        err_clr
);

  // Synchronised bus lines
  logic s_clk, s_mosi, s_cs, s_frame;
  // Previous synchronised samples for edge detection
  logic clk_prev, cs_prev;
  logic clk_rise, clk_fall, cs_fall;

  // FSM state and datapath
  state_t               state;
  logic                 framed;
  logic                 first_word;
  logic [2:0]           bit_cnt;
  logic [1:0]           byte_cnt;
  logic [4:0]           word_pos;
  logic [WORD_BITS-1:0] rx_shift;
  logic [WORD_BITS-1:0] tx_shift;
  logic [WORD_BITS-1:0] tx_word;
  logic                 abort;
  logic                 set_overflow, set_underrun, set_frame;

  spi_sync #(.N(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(spi_clk), .q(s_clk)
  );
  spi_sync #(.N(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(spi_mosi), .q(s_mosi)
  );
  spi_sync #(.N(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .rst_val(1'b1), .d(spi_cs), .q(s_cs)
  );
  spi_sync #(.N(SYNC_STAGES)) u_sync_frame (
    .clk(clk), .rst(rst), .rst_val(1'b1), .d(spi_frame), .q(s_frame)
  );

  // Remember the last synchronised clk and cs samples for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      clk_prev <= s_clk;
      cs_prev  <= s_cs;
    end
  end

  assign clk_rise = s_clk & ~clk_prev;
  assign clk_fall = ~s_clk & clk_prev;
  assign cs_fall  = cs_prev & ~s_cs;
  assign word_pos = {byte_cnt, bit_cnt};
  assign tx_ready = (state == ST_LOAD);

  // Next tx word, abort condition and one-cycle error events.
  always_comb begin
    tx_word = '0;
    if (tx_valid) begin
      tx_word = (~s_frame) ? tx_data : {24'b0, tx_data[7:0]};
    end
    // A mode flip is measured against the mode latched at LOAD.
    abort        = s_cs | ((~s_frame) != framed);
    set_underrun = (state == ST_LOAD) && !tx_valid;
    set_overflow = (state == ST_DONE) && rx_valid && !rx_ready;
    set_frame    = (state == ST_SHIFT) && abort &&
                   ((bit_cnt != 3'd0) || (byte_cnt != 2'd0));
  end

  // Main FSM: word framing, bit shifting, miso drive and rx output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      framed     <= 1'b0;
      first_word <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      spi_miso   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_oob     <= 1'b0;
      rx_data    <= '0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          spi_miso <= 1'b0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (cs_fall) begin
            state      <= ST_LOAD;
            first_word <= 1'b1;
          end
        end
        ST_LOAD: begin
          framed     <= ~s_frame;
          tx_shift   <= tx_word;
          rx_shift   <= '0;
          bit_cnt    <= '0;
          byte_cnt   <= '0;
          first_word <= 1'b0;
          // Only the word right after cs assertion has no preceding falling
          // edge to present bit 0; later words wait for the next fall.
          if (first_word) begin
            spi_miso <= tx_word[0];
          end
          state <= s_cs ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (abort) begin
            state    <= ST_IDLE;
            spi_miso <= 1'b0;
          end else if (clk_rise) begin
            rx_shift[word_pos] <= s_mosi;
            tx_shift           <= tx_shift >> 1;
            if (is_last_bit(framed, byte_cnt, bit_cnt)) begin
              state    <= ST_DONE;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'(BYTE_BITS - 1)) begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end else if (clk_fall) begin
            spi_miso <= tx_shift[0];
          end
        end
        ST_DONE: begin
          // A word still waiting for its handshake wins; the new one is dropped.
          if (!rx_valid || rx_ready) begin
            rx_valid <= 1'b1;
            rx_oob   <= ~framed;
            rx_data  <= framed ? rx_shift : {24'b0, rx_shift[7:0]};
          end
          state <= s_cs ? ST_IDLE : ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a fresh event outranks a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_underrun <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      err_overflow <= (err_overflow & ~err_clr) | set_overflow;
      err_underrun <= (err_underrun & ~err_clr) | set_underrun;
      err_frame    <= (err_frame    & ~err_clr) | set_frame;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: table of single-word transfers, randomized
// multi-word transfers against a word-level model, and hand sequences for
// overflow, framing error and reset mid-word.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, spi_mosi, spi_cs, spi_frame;
  logic        spi_miso;
  logic        rx_valid, rx_ready, rx_oob;
  logic [31:0] rx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic        err_overflow, err_underrun, err_frame, err_clr;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  logic [31:0] tw[3];
  logic [32:0] te[3];

  typedef struct {
    logic        oob;
    logic        txv;
    logic [31:0] txd;
    logic [31:0] mosi;
    logic [32:0] exp_rx;
    logic [31:0] exp_miso;
    logic        exp_und;
  } vec_t;

  vec_t vecs[6];

  spi_slave_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_frame(spi_frame),
    .spi_miso(spi_miso),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_oob(rx_oob),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .err_overflow(err_overflow), .err_underrun(err_underrun), .err_frame(err_frame),
    .err_clr(err_clr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every rx handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: got oob=%0b data=%08h, none expected", rx_oob, rx_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({rx_oob, rx_data} !== e) begin
          bad++;
          $display("FAIL rx_word: got oob=%0b data=%08h want oob=%0b data=%08h",
                   rx_oob, rx_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Word-level reference model
  function automatic logic [32:0] model_rx(input logic oob, input logic [31:0] w);
    return oob ? {1'b1, 32'(w % 256)} : {1'b0, w};
  endfunction

  function automatic logic [31:0] model_miso(input logic oob, input logic txv, input logic [31:0] txd);
    if (!txv) return 32'd0;
    return oob ? 32'(txd % 256) : txd;
  endfunction

  // Driver: clock nbits out LSB first, capture miso at each rising edge.
  task automatic xfer(input logic [31:0] mo, input int nbits, input int half, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[i];
      repeat (half) @(negedge clk);
      spi_clk = 1'b1;
      mi[i] = spi_miso;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  // Driver: one cs-low transfer of nwords words from tw[]; te[] pushed if push.
  task automatic run_xfer(input logic oob, input logic txv, input logic [31:0] txd,
                          input int nwords, input logic [31:0] exp_mi, input logic push);
    int half;
    logic [31:0] mi;
    half = $urandom_range(4, 7);
    spi_frame = oob;
    tx_valid  = txv;
    tx_data   = txd;
    @(negedge clk) spi_cs = 1'b0;
    repeat (half) @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      if (push) exp_q.push_back(te[w]);
      xfer(tw[w], oob ? 8 : 32, half, mi);
      check("miso_word", {32'd0, mi}, {32'd0, exp_mi});
    end
    repeat (half) @(negedge clk);
    spi_cs = 1'b1;
    repeat (3 * half + 8) @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] mi;
    // Reset and idle bus
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; spi_frame = 1'b1;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0; err_clr = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 32'hA5A5_1234, 32'hDEAD_BEEF, {1'b0, 32'hDEAD_BEEF}, 32'hA5A5_1234, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h7777_77C3, 32'h0000_003C, {1'b1, 32'h0000_003C}, 32'h0000_00C3, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_1234, {1'b0, 32'h0F0F_1234}, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0081, {1'b1, 32'h0000_0081}, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, {1'b0, 32'h0000_0000}, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, {1'b1, 32'h0000_00FF}, 32'h0000_0080, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {26'd0, spi_miso, rx_valid, rx_oob, tx_ready, err_overflow, err_underrun, err_frame, rx_data}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven single-word transfers
    foreach (vecs[k]) begin
      tw[0] = vecs[k].mosi;
      te[0] = vecs[k].exp_rx;
      run_xfer(vecs[k].oob, vecs[k].txv, vecs[k].txd, 1, vecs[k].exp_miso, 1'b1);
      check("rx_drained", 64'(exp_q.size()), 64'd0);
      check("err_underrun", {63'd0, err_underrun}, {63'd0, vecs[k].exp_und});
      pulse_clr();
    end

    // Randomized multi-word transfers
    for (int n = 0; n < 16; n++) begin
      logic oob, txv;
      logic [31:0] txd;
      int nw;
      oob = 1'($urandom_range(0, 1));
      txv = ($urandom_range(0, 3) != 0);
      txd = $urandom;
      nw  = $urandom_range(1, 2);
      for (int w = 0; w < nw; w++) begin
        tw[w] = $urandom;
        te[w] = model_rx(oob, tw[w]);
      end
      run_xfer(oob, txv, txd, nw, model_miso(oob, txv, txd), 1'b1);
      check("rand_rx_drained", 64'(exp_q.size()), 64'd0);
      check("rand_errors", {61'd0, err_overflow, err_underrun, err_frame}, {61'd0, 1'b0, !txv, 1'b0});
      pulse_clr();
    end

    // Overflow: two framed words with rx_ready low
    rx_ready = 1'b0;
    tw[0] = 32'h1111_1111;
    tw[1] = 32'h2222_2222;
    run_xfer(1'b0, 1'b1, 32'h0BAD_CAFE, 2, 32'h0BAD_CAFE, 1'b0);
    check("ovf_valid", {63'd0, rx_valid}, 64'd1);
    check("ovf_data", {32'd0, rx_data}, {32'd0, 32'h1111_1111});
    check("ovf_flag", {63'd0, err_overflow}, 64'd1);
    exp_q.push_back({1'b0, 32'h1111_1111});
    @(negedge clk) rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovf_drained", 64'(exp_q.size()), 64'd0);
    check("ovf_no_second", {63'd0, rx_valid}, 64'd0);
    pulse_clr();
    check("err_clr", {61'd0, err_overflow, err_underrun, err_frame}, 64'd0);

    // Framing error: cs raised after 12 bits
    spi_frame = 1'b0; tx_valid = 1'b1; tx_data = 32'h1357_9BDF;
    @(negedge clk) spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    xfer(32'hFFFF_FFFF, 12, 5, mi);
    repeat (5) @(negedge clk);
    spi_cs = 1'b1;
    repeat (20) @(negedge clk);
    tx_valid = 1'b0;
    check("frm_flag", {63'd0, err_frame}, 64'd1);
    check("frm_no_rx", {63'd0, rx_valid}, 64'd0);
    tw[0] = 32'hCAFE_0042;
    te[0] = model_rx(1'b0, tw[0]);
    run_xfer(1'b0, 1'b1, 32'h8765_4321, 1, 32'h8765_4321, 1'b1);
    check("frm_next_word", 64'(exp_q.size()), 64'd0);
    check("frm_sticky", {63'd0, err_frame}, 64'd1);
    pulse_clr();

    // Reset mid-word: after two bytes
    spi_frame = 1'b0; tx_valid = 1'b1; tx_data = 32'h5555_AAAA;
    @(negedge clk) spi_cs = 1'b0;
    repeat (5) @(negedge clk);
    xfer(32'hCAFE_F00D, 16, 5, mi);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          {26'd0, spi_miso, rx_valid, rx_oob, tx_ready, err_overflow, err_underrun, err_frame, rx_data}, 64'd0);
    spi_cs = 1'b1; tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_rx", {62'd0, rx_valid, err_frame}, 64'd0);
    tw[0] = 32'h600D_F00D;
    te[0] = model_rx(1'b0, tw[0]);
    run_xfer(1'b0, 1'b1, 32'h0F1E_2D3C, 1, 32'h0F1E_2D3C, 1'b1);
    check("rst_next_word", 64'(exp_q.size()), 64'd0);

    repeat (10) @(negedge clk);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
